id_stage: RTL

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. Owns the IF/ID pipeline register, the 32×32 general register file, and opcode decode. Also owns load-use hazard detection and branch resolution. Returns branch redirect and freeze requests to fetch, and presents decoded operands and controls to the ID/EX register.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/id_stage_register_file.sv | 36 +++
 rtl/id_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA definitions: opcodes, ALU command encodings and instruction field positions.
package cpu_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_SRL = 4'b1010;

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file, two combinational read ports, one write port; r0 is hardwired to zero.
// Optional same-cycle write-through on the read ports when REGFILE_BYPASS_EN is defined.
module register_file
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem_q[raddr1_i];
        rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
        if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i != 5'd0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, opcode decode, load-use stall and branch resolution.
// Register file write-through is selected by the REGFILE_BYPASS_EN macro.
module id_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    output logic        if_freeze,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_val1,
    output logic [31:0] id_val2,
    output logic [31:0] id_st_val,
    output logic [4:0]  id_src1,
    output logic [4:0]  id_src2,
    output logic [4:0]  id_dest,
    output logic [3:0]  id_alu_cmd,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_wb_en
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    logic [5:0]         op;
    logic [4:0]         rs, rt, rd;
    logic signed [31:0] imm_sext;
    logic [31:0]        rs_val, rt_val;

    logic       use_rs, use_rt, use_imm, dest_rd, dest_rt;
    logic       mem_rd, mem_wr, wb, br_cond;
    logic [3:0] alu;
    logic       stall;

    assign op       = instr_q[OP_MSB:OP_LSB];
    assign rs       = instr_q[RS_MSB:RS_LSB];
    assign rt       = instr_q[RT_MSB:RT_LSB];
    assign rd       = instr_q[RD_MSB:RD_LSB];
    assign imm_sext = {{16{instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};

    register_file u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rs_val),
        .rdata2_o (rt_val),
        .we_i     (wb_en),
        .waddr_i  (wb_dest),
        .wdata_i  (wb_data)
    );

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        use_imm = 1'b0;
        dest_rd = 1'b0;
        dest_rt = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        wb      = 1'b0;
        br_cond = 1'b0;
        alu     = ALU_ADD;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR,
            OP_SLA, OP_SLL, OP_SRA, OP_SRL: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                dest_rd = 1'b1;
                wb      = 1'b1;
                case (op)
                    OP_SUB:         alu = ALU_SUB;
                    OP_AND:         alu = ALU_AND;
                    OP_OR:          alu = ALU_OR;
                    OP_NOR:         alu = ALU_NOR;
                    OP_XOR:         alu = ALU_XOR;
                    OP_SLA, OP_SLL: alu = ALU_SLL;
                    OP_SRA:         alu = ALU_SRA;
                    OP_SRL:         alu = ALU_SRL;
                    default:        alu = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_LD: begin
                use_rs  = 1'b1;
                use_imm = 1'b1;
                dest_rt = 1'b1;
                wb      = 1'b1;
                mem_rd  = (op == OP_LD);
                alu     = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            OP_ST: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                use_imm = 1'b1;
                mem_wr  = 1'b1;
            end
            OP_BEZ: begin
                use_rs  = 1'b1;
                br_cond = (rs_val == 32'd0);
            end
            OP_BNE: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                br_cond = (rs_val != rt_val);
            end
            OP_JMP:  br_cond = 1'b1;
            default: ;
        endcase
    end

    // Only sources the instruction actually reads can create a load-use hazard.
    assign stall = ex_mem_read && (ex_dest != 5'd0) &&
                   ((use_rs && (ex_dest == rs)) || (use_rt && (ex_dest == rt)));

    assign if_freeze    = stall;
    assign br_taken     = br_cond && !stall;
    assign br_addr      = pc_q + 32'd4 + {imm_sext[29:0], 2'b00};
    assign id_pc        = pc_q + 32'd4;
    assign id_val1      = use_rs ? rs_val : 32'd0;
    assign id_val2      = use_imm ? imm_sext : (use_rt ? rt_val : 32'd0);
    assign id_st_val    = mem_wr ? rt_val : 32'd0;
    assign id_src1      = use_rs ? rs : 5'd0;
    assign id_src2      = use_rt ? rt : 5'd0;
    assign id_dest      = dest_rd ? rd : (dest_rt ? rt : 5'd0);
    assign id_alu_cmd   = alu;
    assign id_mem_read  = mem_rd && !stall;
    assign id_mem_write = mem_wr && !stall;
    assign id_wb_en     = wb && !stall;

    // IF/ID: hold on stall, squash the wrong-path fetch on a taken branch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (!stall) begin
            pc_d    = if_pc;
            instr_d = br_taken ? 32'd0 : if_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule
